// File: rtl/cond_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | cond_ctrl_pkg : condition codes, flag indices and bubble bundles          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package cond_ctrl_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_write;
      logic       memto_reg;
      logic       branch;
      logic       pc_src;
      logic [1:0] flag_write;
      logic [3:0] cond;
   } e_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_write;
      logic memto_reg;
      logic pc_src;
   } m_ctrl_t;

   localparam e_ctrl_t E_BUBBLE = '0;
   localparam m_ctrl_t M_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/cond_ctrl_pipe_if.sv
// +--------------------------------------------------------------------------+
// | cond_ctrl_pipe_if : decode-side controls, hazard inputs, pipeline outputs |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cond_ctrl_pipe_if #(
   parameter int EW    = 11,
   parameter int CNT_W = 32
);
   logic          RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD;
   logic [1:0]    FlagWriteD;
   logic [3:0]    CondD;
   logic [EW-1:0] ExD;
   logic          ValidD;
   logic [3:0]    ALUFlags;
   logic          StallE, FlushE;

   logic [EW-1:0]    ExE;
   logic             MemtoRegE, CondExE, BranchTakenE, PCSrcE, CarryIn;
   logic             RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
   logic             RegWriteW, MemtoRegW, PCSrcW;
   logic [3:0]       FlagsQ;
   logic [CNT_W-1:0] SquashCnt, StallCnt;

   modport master (
      output RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD, FlagWriteD, CondD,
             ExD, ValidD, ALUFlags, StallE, FlushE,
      input  ExE, MemtoRegE, CondExE, BranchTakenE, PCSrcE, CarryIn,
             RegWriteM, MemWriteM, MemtoRegM, PCSrcM, RegWriteW, MemtoRegW, PCSrcW,
             FlagsQ, SquashCnt, StallCnt
   );

   modport slave (
      input  RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD, FlagWriteD, CondD,
             ExD, ValidD, ALUFlags, StallE, FlushE,
      output ExE, MemtoRegE, CondExE, BranchTakenE, PCSrcE, CarryIn,
             RegWriteM, MemWriteM, MemtoRegM, PCSrcM, RegWriteW, MemtoRegW, PCSrcW,
             FlagsQ, SquashCnt, StallCnt
   );
endinterface

`default_nettype wire

// File: rtl/cond_check.sv
// +--------------------------------------------------------------------------+
// | cond_check : combinational ARM condition-code evaluation                  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module cond_check
   import cond_ctrl_pkg::*;
(
   input  wire logic [3:0] CondE,
   input  wire logic [3:0] FlagsQ,
   output logic            CondExE
);

   logic n, z, c, v;

   always_comb begin
      n = FlagsQ[FLAG_N];
      z = FlagsQ[FLAG_Z];
      c = FlagsQ[FLAG_C];
      v = FlagsQ[FLAG_V];
      CondExE = 1'b0;
      case (CondE)
         COND_EQ: CondExE = z;
         COND_NE: CondExE = !z;
         COND_CS: CondExE = c;
         COND_CC: CondExE = !c;
         COND_MI: CondExE = n;
         COND_PL: CondExE = !n;
         COND_VS: CondExE = v;
         COND_VC: CondExE = !v;
         COND_HI: CondExE = c & !z;
         COND_LS: CondExE = !c | z;
         COND_GE: CondExE = (n == v);
         COND_LT: CondExE = (n != v);
         COND_GT: CondExE = !z & (n == v);
         COND_LE: CondExE = z | (n != v);
         COND_AL: CondExE = 1'b1;
         default: CondExE = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/cond_ctrl_pipe.sv
// +--------------------------------------------------------------------------+
// | cond_ctrl_pipe : E/M/W control pipeline with conditional execution and    |
// | architectural flags; counters built only with COND_CTRL_PIPE_PERF_EN.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module cond_ctrl_pipe
   import cond_ctrl_pkg::*;
#(
   parameter int EW    = 11,
   parameter int CNT_W = 32
)(
   input  wire logic       clk,
   input  wire logic       reset,
   cond_ctrl_pipe_if.slave bus
);

   e_ctrl_t       e_q, e_d;
   logic [EW-1:0] ex_q, ex_d;
   m_ctrl_t       m_q, m_d, w_q, w_d;
   logic [3:0]    flags_q, flags_d;
   logic          cond_pass, cond_ex;

   cond_check u_cond_check (
      .CondE   (e_q.cond),
      .FlagsQ  (flags_q),
      .CondExE (cond_pass)
   );

   assign cond_ex = e_q.valid & cond_pass;

   always_comb begin
      e_d  = e_q;
      ex_d = ex_q;
      if (bus.FlushE) begin
         e_d  = E_BUBBLE;
         ex_d = '0;
      end else if (!bus.StallE) begin
         if (bus.ValidD) begin
            e_d.valid      = 1'b1;
            e_d.reg_write  = bus.RegWriteD;
            e_d.mem_write  = bus.MemWriteD;
            e_d.memto_reg  = bus.MemtoRegD;
            e_d.branch     = bus.BranchD;
            e_d.pc_src     = bus.PCSrcD;
            e_d.flag_write = bus.FlagWriteD;
            e_d.cond       = bus.CondD;
            ex_d           = bus.ExD;
         end else begin
            e_d  = E_BUBBLE;
            ex_d = '0;
         end
      end
   end

   // A stalled E never reaches M, even when it is being flushed at the same time.
   always_comb begin
      m_d = M_BUBBLE;
      if (!bus.StallE) begin
         m_d.reg_write = e_q.reg_write & cond_ex;
         m_d.mem_write = e_q.mem_write & cond_ex;
         m_d.memto_reg = e_q.memto_reg;
         m_d.pc_src    = e_q.pc_src & cond_ex;
      end
      w_d = m_q;
   end

   always_comb begin
      flags_d = flags_q;
      if (!bus.StallE && cond_ex) begin
         if (e_q.flag_write[1]) begin
            flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
         end
         if (e_q.flag_write[0]) begin
            flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
            flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q     <= E_BUBBLE;
         ex_q    <= '0;
         m_q     <= M_BUBBLE;
         w_q     <= M_BUBBLE;
         flags_q <= 4'b0000;
      end else begin
         e_q     <= e_d;
         ex_q    <= ex_d;
         m_q     <= m_d;
         w_q     <= w_d;
         flags_q <= flags_d;
      end
   end

   assign bus.ExE          = ex_q;
   assign bus.MemtoRegE    = e_q.memto_reg;
   assign bus.CondExE      = cond_ex;
   assign bus.BranchTakenE = e_q.branch & cond_ex;
   assign bus.PCSrcE       = e_q.pc_src;
   assign bus.CarryIn      = flags_q[FLAG_C];
   assign bus.RegWriteM    = m_q.reg_write;
   assign bus.MemWriteM    = m_q.mem_write;
   assign bus.MemtoRegM    = m_q.memto_reg;
   assign bus.PCSrcM       = m_q.pc_src;
   assign bus.RegWriteW    = w_q.reg_write;
   assign bus.MemtoRegW    = w_q.memto_reg;
   assign bus.PCSrcW       = w_q.pc_src;
   assign bus.FlagsQ       = flags_q;

`ifdef COND_CTRL_PIPE_PERF_EN
   logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d, stall_cnt_q, stall_cnt_d;

   // Both counters saturate at all-ones rather than wrapping.
   always_comb begin
      squash_cnt_d = squash_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (e_q.valid && !cond_pass && !bus.StallE && (squash_cnt_q != '1))
         squash_cnt_d = squash_cnt_q + CNT_W'(1);
      if (bus.StallE && e_q.valid && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         squash_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         squash_cnt_q <= squash_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.SquashCnt = squash_cnt_q;
   assign bus.StallCnt  = stall_cnt_q;
`else
   assign bus.SquashCnt = {CNT_W{1'b0}};
   assign bus.StallCnt  = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire
